axi_sram_slave_model: RTL
=========================

Name: axi_sram_slave_model

Overview:
- Synthesizable single-beat AXI slave with internal word-addressed storage.
- It is the responder end of the fake_cpu AXI master port. It stands in for axi_sram_bridge plus SRAM in unit benches, and can back a second address window in top.
- It accepts independent AW/W/B and AR/R traffic, applies byte strobes, and returns OKAY or SLVERR.

Parameters:
- ADDR_WIDTH, 32: width of awaddr/araddr.
- DATA_WIDTH, 64: data width; fixed 8-byte words, wstrb is DATA_WIDTH/8 bits.
- DEPTH, 256: number of 64-bit words stored.
- BASE_ADDR, 32'h0: byte address of word 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- awaddr  in  ADDR_WIDTH  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte enables.
- wlast  in  1  last beat; must be 1 (single beat).
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response: 00 OKAY, 10 SLVERR.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- araddr  in  ADDR_WIDTH  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  read response: 00 OKAY, 10 SLVERR.
- rlast  out  1  always equals rvalid.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.

Behaviour:
- Reset, asynchronous: all outputs go to 0 immediately, both FSMs go to IDLE, captured address/data flags clear. Storage is not reset; reading a never-written word returns undefined data.
- Ready outputs are registered. awready, wready and arready rise on the first rising edge after resetn deasserts.
- Address decode:
  - idx = (addr - BASE_ADDR) >> 3; addr[2:0] ignored.
  - In range iff addr >= BASE_ADDR and idx < DEPTH.
- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - W_IDLE: awready=1, wready=1.
  - AW handshake alone -> W_HAVE_AW (awready=0, wready=1).
  - W handshake alone -> W_HAVE_W (wready=0, awready=1).
  - Both in the same cycle -> commit.
  - Commit: occurs on the edge completing the second handshake. Memory is updated byte-wise per wstrb, only if in range and wlast=1. bvalid=1 next cycle. bresp=00, or 10 if out of range or wlast=0 (no write in that case). State -> W_RESP with awready=wready=0.
  - W_RESP: bvalid and bresp held stable until bready=1. On the bvalid&bready edge -> W_IDLE, bvalid=0, readies=1 the following cycle.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On arvalid&arready, capture idx -> R_DATA; arready=0.
  - R_DATA: rvalid=1, rlast=1 the cycle after the AR handshake, i.e. 1-cycle latency. rdata = mem[idx] sampled at that edge; 0 with rresp=10 if out of range.
  - rdata, rresp and rvalid held stable while rready=0. On the rvalid&rready edge -> R_IDLE, rvalid=0, arready=1 next cycle.
- Read and write channels are fully independent and may be active in the same cycle.
- Same-word collision: if a write commit and the read data sample occur on the same edge, the read returns the pre-write contents (read-before-write).
- valid inputs while the corresponding ready=0 are ignored; no queuing beyond one outstanding read and one outstanding write.
- A burst length is not decoded; every transaction is one beat.

Test Plan:
- Write then read:
  - Stimulus: awaddr=0x4, wdata=64'habcdaaaa12345678, wstrb=FF, wlast=1, AW and W in the same cycle.
  - Response: bvalid=1, bresp=00 one cycle later. Then araddr=0x4 -> rvalid=1 the next cycle, rdata=64'habcdaaaa12345678, rresp=00, rlast=1.
- W before AW:
  - Stimulus: W at cycle 0, AW at cycle 3.
  - Response: wready=0 from cycle 1, awready stays 1, bvalid=1 at cycle 4, memory updated.
- Strobes:
  - Stimulus: after the first test, write 0x0 with wdata=64'h00000000aabbccdd, wstrb=8'h0F.
  - Response: read 0x18 (unwritten) is accepted with OKAY; read 0x0 returns 64'habcdaaaaaabbccdd.
- Backpressure:
  - Stimulus: rready=0 and bready=0 for 5 cycles after valid.
  - Response: rvalid/rdata/rresp and bvalid/bresp stable throughout; arready=0, awready=0, wready=0. Release -> valid drops next edge, readies return to 1.
- Out of range:
  - Stimulus: write to BASE_ADDR+DEPTH*8, wstrb=FF.
  - Response: bresp=10, no word changes. Read the same address -> rresp=10, rdata=0. Write with wlast=0 -> bresp=10, no write.
- Reset mid-transaction and collision:
  - Stimulus: assert resetn=0 while bvalid=1 and rvalid=1.
  - Response: both drop with no clock edge; readies=1 on the first edge after release.
  - Collision: AR to 0x8 on the same edge as a write commit to 0x8 returns the old value.

Source files
------------

// File: rtl/axi_sram_slave_model.sv
// Single-beat AXI slave backed by a word-addressed storage array.
// Write and read channels run independent FSMs; all handshake outputs
// are registered. Reads sample storage on the AR handshake edge, so a
// write committing on that same edge is not visible (read-before-write).
module axi_sram_slave_model #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    DEPTH      = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // Word index relative to the window base; the low three byte-offset bits drop out.
  function automatic logic [ADDR_WIDTH-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] offset;
    offset = addr - BASE_ADDR;
    return offset >> 3;
  endfunction

  // Address lies inside the window: not below the base and word index below DEPTH.
  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr,
                                     input logic [ADDR_WIDTH-1:0] word);
    return (addr >= BASE_ADDR) && (word < ADDR_WIDTH'(DEPTH));
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  w_state_t              w_state_r, w_state_s;
  logic                  awready_r, wready_r, bvalid_r;
  logic [1:0]            bresp_r, bresp_s;
  logic [ADDR_WIDTH-1:0] aw_addr_r;
  logic [DATA_WIDTH-1:0] w_data_r;
  logic [STRB_WIDTH-1:0] w_strb_r;
  logic                  w_last_r;

  logic                  aw_hs_s, w_hs_s, commit_s, commit_ok_s;
  logic [ADDR_WIDTH-1:0] commit_addr_s, commit_word_s;
  logic [DATA_WIDTH-1:0] commit_data_s;
  logic [STRB_WIDTH-1:0] commit_strb_s;
  logic                  commit_last_s;
  logic [IDX_WIDTH-1:0]  commit_idx_s;

  r_state_t              r_state_r, r_state_s;
  logic                  arready_r, rvalid_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [1:0]            rresp_r;
  logic                  ar_hs_s, ar_ok_s;
  logic [ADDR_WIDTH-1:0] ar_word_s;
  logic [IDX_WIDTH-1:0]  ar_idx_s;

  assign aw_hs_s = awvalid & awready_r;
  assign w_hs_s  = wvalid & wready_r;
  assign ar_hs_s = arvalid & arready_r;

  // Select commit operands: a channel already captured comes from its register, the other live.
  always_comb begin
    commit_addr_s = awaddr;
    commit_data_s = wdata;
    commit_strb_s = wstrb;
    commit_last_s = wlast;
    if (w_state_r == W_HAVE_AW) begin
      commit_addr_s = aw_addr_r;
    end else begin
      commit_addr_s = awaddr;
    end
    if (w_state_r == W_HAVE_W) begin
      commit_data_s = w_data_r;
      commit_strb_s = w_strb_r;
      commit_last_s = w_last_r;
    end else begin
      commit_data_s = wdata;
      commit_strb_s = wstrb;
      commit_last_s = wlast;
    end
    commit_word_s = word_index(commit_addr_s);
    commit_idx_s  = commit_word_s[IDX_WIDTH-1:0];
    commit_ok_s   = in_window(commit_addr_s, commit_word_s) && commit_last_s;
  end

  // Write FSM next state; commit fires on the edge completing the second handshake.
  always_comb begin
    w_state_s = w_state_r;
    commit_s  = 1'b0;
    bresp_s   = bresp_r;
    case (w_state_r)
      W_IDLE: begin
        if (aw_hs_s && w_hs_s) begin
          commit_s  = 1'b1;
          w_state_s = W_RESP;
        end else if (aw_hs_s) begin
          w_state_s = W_HAVE_AW;
        end else if (w_hs_s) begin
          w_state_s = W_HAVE_W;
        end else begin
          w_state_s = W_IDLE;
        end
      end
      W_HAVE_AW: begin
        if (w_hs_s) begin
          commit_s  = 1'b1;
          w_state_s = W_RESP;
        end else begin
          w_state_s = W_HAVE_AW;
        end
      end
      W_HAVE_W: begin
        if (aw_hs_s) begin
          commit_s  = 1'b1;
          w_state_s = W_RESP;
        end else begin
          w_state_s = W_HAVE_W;
        end
      end
      W_RESP: begin
        if (bvalid_r && bready) begin
          w_state_s = W_IDLE;
        end else begin
          w_state_s = W_RESP;
        end
      end
      default: w_state_s = W_IDLE;
    endcase
    if (commit_s) begin
      bresp_s = commit_ok_s ? RESP_OKAY : RESP_SLVERR;
    end else begin
      bresp_s = bresp_r;
    end
  end

  // Write channel registers: state, registered readies/response, captured AW/W payloads.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
      aw_addr_r <= '0;
      w_data_r  <= '0;
      w_strb_r  <= '0;
      w_last_r  <= 1'b0;
    end else begin
      w_state_r <= w_state_s;
      awready_r <= (w_state_s == W_IDLE) || (w_state_s == W_HAVE_W);
      wready_r  <= (w_state_s == W_IDLE) || (w_state_s == W_HAVE_AW);
      bvalid_r  <= (w_state_s == W_RESP);
      bresp_r   <= bresp_s;
      if (aw_hs_s) begin
        aw_addr_r <= awaddr;
      end
      if (w_hs_s) begin
        w_data_r <= wdata;
        w_strb_r <= wstrb;
        w_last_r <= wlast;
      end
    end
  end

  // Storage update: byte lanes enabled by the strobe on an accepted in-window commit.
  always_ff @(posedge clk) begin
    if (commit_s && commit_ok_s) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (commit_strb_s[b]) begin
          mem_r[commit_idx_s][8*b +: 8] <= commit_data_s[8*b +: 8];
        end
      end
    end
  end

  // Read address decode for the live AR request.
  always_comb begin
    ar_word_s = word_index(araddr);
    ar_idx_s  = ar_word_s[IDX_WIDTH-1:0];
    ar_ok_s   = in_window(araddr, ar_word_s);
  end

  // Read FSM next state.
  always_comb begin
    r_state_s = r_state_r;
    case (r_state_r)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_state_s = R_DATA;
        end else begin
          r_state_s = R_IDLE;
        end
      end
      R_DATA: begin
        if (rvalid_r && rready) begin
          r_state_s = R_IDLE;
        end else begin
          r_state_s = R_DATA;
        end
      end
      default: r_state_s = R_IDLE;
    endcase
  end

  // Read channel registers; data/resp are loaded only on the AR handshake and then held.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= '0;
      rresp_r   <= 2'b00;
    end else begin
      r_state_r <= r_state_s;
      arready_r <= (r_state_s == R_IDLE);
      rvalid_r  <= (r_state_s == R_DATA);
      if (ar_hs_s) begin
        if (ar_ok_s) begin
          rdata_r <= mem_r[ar_idx_s];
          rresp_r <= RESP_OKAY;
        end else begin
          rdata_r <= '0;
          rresp_r <= RESP_SLVERR;
        end
      end
    end
  end

  assign awready = awready_r;
  assign wready  = wready_r;
  assign bvalid  = bvalid_r;
  assign bresp   = bresp_r;
  assign arready = arready_r;
  assign rvalid  = rvalid_r;
  assign rlast   = rvalid_r;
  assign rdata   = rdata_r;
  assign rresp   = rresp_r;

endmodule
